// File: rtl/acoustic_burst_gen.sv
// -----------------------------------------------------------------------------
// acoustic_burst_gen
//
// Multi-channel square-wave burst generator for the USBL transmit chain. A
// burst is BURST_CYCLES carrier periods (2*HALF_PERIOD clocks each) driven on
// every unmasked channel. Each channel's burst is offset by its own start
// delay. Bursts repeat every REP_CYCLES clocks in free-run mode (i_mode=0) or
// fire once per trigger (i_mode=1).
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   i_enable       master enable (level)
//   i_mode         0 = free-running repetition, 1 = triggered single-shot
//   i_trigger      burst request in mode 1, sampled only in IDLE
//   i_ch_delay     per-channel start delay, channel c at [c*DLY_W +: DLY_W]
//   i_ch_mask      1 = channel participates in the burst
//   o_signal       registered carrier outputs, one per channel
//   o_busy         high while in BURST or SLEEP
//   o_burst_start  one-cycle pulse on entry to BURST
// -----------------------------------------------------------------------------
module acoustic_burst_gen #(
  parameter int unsigned HALF_PERIOD  = 625,
  parameter int unsigned BURST_CYCLES = 80,
  parameter int unsigned REP_CYCLES   = 100000000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DLY_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_mode,
  input  logic                    i_trigger,
  input  logic [NUM_CH*DLY_W-1:0] i_ch_delay,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  output logic [NUM_CH-1:0]       o_signal,
  output logic                    o_busy,
  output logic                    o_burst_start
);

  localparam int unsigned PERIOD    = 2 * HALF_PERIOD;
  localparam int unsigned BURST_LEN = PERIOD * BURST_CYCLES;
  localparam int unsigned T_W       = $clog2((64'd1 << DLY_W) + 64'(BURST_LEN));
  localparam int unsigned R_W       = $clog2(REP_CYCLES + 1);
  localparam int unsigned P_W       = $clog2(PERIOD);
  localparam int unsigned C_W       = $clog2(BURST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_SLEEP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_start;

  // Configuration captured at burst start
  logic [NUM_CH*DLY_W-1:0] r_dly;
  logic [NUM_CH-1:0]       r_mask;
  logic [T_W-1:0]          r_t_end;

  // Timeline, repetition and per-channel carrier counters
  logic [T_W-1:0]          r_t;
  logic [R_W-1:0]          r_rep;
  logic [P_W-1:0]          r_ph [NUM_CH];
  logic [C_W-1:0]          r_pc [NUM_CH];

  logic [NUM_CH-1:0]       r_signal;
  logic                    r_busy;
  logic                    r_burst_start;
  logic                    r_idle_hold;

  logic [DLY_W-1:0]        w_dmax;
  logic [T_W-1:0]          w_t_end_in;
  logic                    w_t_last;
  logic                    w_rep_last;
  logic                    w_rep_pen;
  logic [NUM_CH-1:0]       w_act;
  logic [NUM_CH-1:0]       w_sig;

  // Largest delay among participating channels (0 when none participate)
  always_comb begin
    w_dmax = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch_mask[c] && (i_ch_delay[c*DLY_W +: DLY_W] > w_dmax)) begin
        w_dmax = i_ch_delay[c*DLY_W +: DLY_W];
      end
    end
  end

  assign w_t_end_in = T_W'(w_dmax) + T_W'(BURST_LEN - 1);
  assign w_t_last   = (r_t == r_t_end);
  // r_rep saturates at REP_CYCLES-1: the repetition interval has fully elapsed
  assign w_rep_last = (r_rep == R_W'(REP_CYCLES - 1));
  // Next cycle completes the interval; that cycle is the IDLE slot before restart
  assign w_rep_pen  = ((r_rep + R_W'(1)) == R_W'(REP_CYCLES - 1));

  // Channel is in its window until it has produced all carrier periods
  always_comb begin
    w_act = '0;
    w_sig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_act[c] = r_mask[c]
               && (r_t >= T_W'(r_dly[c*DLY_W +: DLY_W]))
               && (r_pc[c] != C_W'(BURST_CYCLES));
      w_sig[c] = w_act[c] && (r_ph[c] < P_W'(HALF_PERIOD));
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; w_start marks every entry into a fresh burst
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The first IDLE cycle after a burst does not accept a trigger
        if (i_enable && (!i_mode || (i_trigger && !r_idle_hold))) begin
          w_state_nxt = S_BURST;
          w_start     = 1'b1;
        end
      end
      S_BURST: begin
        if (w_t_last) begin
          if (i_mode || !i_enable) begin
            w_state_nxt = S_IDLE;
          end else if (w_rep_last) begin
            // Burst overran the repetition interval: restart back-to-back
            w_state_nxt = S_BURST;
            w_start     = 1'b1;
          end else if (w_rep_pen) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SLEEP;
          end
        end
      end
      S_SLEEP: begin
        if (!i_enable || w_rep_pen) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: config latch, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly         <= '0;
      r_mask        <= '0;
      r_t_end       <= '0;
      r_t           <= '0;
      r_rep         <= '0;
      r_signal      <= '0;
      r_busy        <= 1'b0;
      r_burst_start <= 1'b0;
      r_idle_hold   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_ph[c] <= '0;
        r_pc[c] <= '0;
      end
    end else begin
      r_busy        <= (w_state_nxt != S_IDLE);
      r_burst_start <= w_start;
      r_idle_hold   <= (w_state_nxt == S_IDLE) && (r_state != S_IDLE);
      r_signal      <= (r_state == S_BURST) ? w_sig : '0;

      if (w_start) begin
        r_dly   <= i_ch_delay;
        r_mask  <= i_ch_mask;
        r_t_end <= w_t_end_in;
        r_t     <= '0;
        r_rep   <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_ph[c] <= '0;
          r_pc[c] <= '0;
        end
      end else begin
        if (r_state == S_BURST) begin
          r_t <= r_t + T_W'(1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (w_act[c]) begin
              if (r_ph[c] == P_W'(PERIOD - 1)) begin
                r_ph[c] <= '0;
                r_pc[c] <= r_pc[c] + C_W'(1);
              end else begin
                r_ph[c] <= r_ph[c] + P_W'(1);
              end
            end
          end
        end
        if ((r_state != S_IDLE) && !w_rep_last) begin
          r_rep <= r_rep + R_W'(1);
        end
      end
    end
  end

  assign o_signal      = r_signal;
  assign o_busy        = r_busy;
  assign o_burst_start = r_burst_start;

endmodule
